// File: rtl/ysyx_24110006_mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
package ysyx_24110006_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [2:0] IFU_SIZE = 3'b010;

endpackage

// File: rtl/ysyx_24110006_rr_arb2.sv
// Two-way round-robin picker; on a tie the master not granted last wins.
module ysyx_24110006_rr_arb2
  import ysyx_24110006_mem_arb_pkg::*;
(
  input  logic   i_clock,
  input  logic   i_reset,
  input  logic   i_req_ifu,
  input  logic   i_req_lsu,
  input  logic   i_grant_taken,
  output owner_t o_pick
);

  owner_t last_grant;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_grant <= OWN_IFU;
    end else if (i_grant_taken) begin
      last_grant <= o_pick;
    end
  end

  always_comb begin
    o_pick = OWN_IFU;
    if (i_req_ifu && i_req_lsu) begin
      if (last_grant == OWN_IFU) begin
        o_pick = OWN_LSU;
      end else begin
        o_pick = OWN_IFU;
      end
    end else if (i_req_lsu) begin
      o_pick = OWN_LSU;
    end
  end

endmodule

// File: rtl/ysyx_24110006_mem_arb.sv
// Shares the core memory port between IFU and LSU with one outstanding
// transaction; fetches killed by an EXU flush are drained silently.
module ysyx_24110006_mem_arb
  import ysyx_24110006_mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_ifu_req_valid,
  output logic            o_ifu_req_ready,
  input  logic [AW-1:0]   i_ifu_addr,
  output logic            o_ifu_resp_valid,
  input  logic            i_lsu_req_valid,
  output logic            o_lsu_req_ready,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic            i_lsu_wen,
  input  logic [DW-1:0]   i_lsu_wdata,
  input  logic [DW/8-1:0] i_lsu_wmask,
  input  logic [2:0]      i_lsu_size,
  output logic            o_lsu_resp_valid,
  output logic [DW-1:0]   o_resp_rdata,
  output logic            o_resp_err,
  output logic            o_s_req_valid,
  input  logic            i_s_req_ready,
  output logic [AW-1:0]   o_s_addr,
  output logic            o_s_wen,
  output logic [DW-1:0]   o_s_wdata,
  output logic [DW/8-1:0] o_s_wmask,
  output logic [2:0]      o_s_size,
  input  logic            i_s_resp_valid,
  input  logic [DW-1:0]   i_s_rdata,
  input  logic            i_s_err
);

  arb_state_t state_q, state_d;
  owner_t     owner_q;
  owner_t     pick;
  logic       kill_q;
  logic       kill_now;
  logic       in_flight;
  logic       accept;
  logic       deliver;

  ysyx_24110006_rr_arb2 u_rr (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_req_ifu    (i_ifu_req_valid),
    .i_req_lsu    (i_lsu_req_valid),
    .i_grant_taken(accept),
    .o_pick       (pick)
  );

  assign in_flight = (state_q == ST_REQ) || (state_q == ST_WAIT);
  // A flush arriving this cycle kills the fetch immediately, not only from next cycle.
  assign kill_now  = kill_q || (i_flush && in_flight && (owner_q == OWN_IFU));

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_REQ;
      ST_REQ:   if (i_s_req_ready) state_d = kill_now ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (i_s_resp_valid) begin
          state_d = ST_IDLE;
        end else if (kill_now) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (i_s_resp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic; every strobe is held low while reset is asserted
  always_comb begin
    o_ifu_req_ready  = 1'b0;
    o_lsu_req_ready  = 1'b0;
    o_s_req_valid    = 1'b0;
    o_ifu_resp_valid = 1'b0;
    o_lsu_resp_valid = 1'b0;
    o_resp_rdata     = '0;
    o_resp_err       = 1'b0;
    accept           = 1'b0;
    deliver          = 1'b0;
    if (!i_reset) begin
      if (state_q == ST_IDLE) begin
        o_ifu_req_ready = (pick == OWN_IFU) && i_ifu_req_valid && !i_flush;
        o_lsu_req_ready = (pick == OWN_LSU) && i_lsu_req_valid;
      end
      accept        = o_ifu_req_ready || o_lsu_req_ready;
      o_s_req_valid = (state_q == ST_REQ);
      deliver       = (state_q == ST_WAIT) && i_s_resp_valid && !kill_now;
      o_ifu_resp_valid = deliver && (owner_q == OWN_IFU);
      o_lsu_resp_valid = deliver && (owner_q == OWN_LSU);
      if (deliver) begin
        o_resp_rdata = i_s_rdata;
        o_resp_err   = i_s_err;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      owner_q <= OWN_IFU;
      kill_q  <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= pick;
      end
      if (state_q == ST_IDLE) begin
        kill_q <= 1'b0;
      end else if (i_flush && in_flight && (owner_q == OWN_IFU)) begin
        kill_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_s_addr  <= '0;
      o_s_wen   <= 1'b0;
      o_s_wdata <= '0;
      o_s_wmask <= '0;
      o_s_size  <= '0;
    end else if (accept) begin
      if (pick == OWN_LSU) begin
        o_s_addr  <= i_lsu_addr;
        o_s_wen   <= i_lsu_wen;
        o_s_wdata <= i_lsu_wdata;
        o_s_wmask <= i_lsu_wmask;
        o_s_size  <= i_lsu_size;
      end else begin
        o_s_addr  <= i_ifu_addr;
        o_s_wen   <= 1'b0;
        o_s_wdata <= '0;
        o_s_wmask <= '0;
        o_s_size  <= IFU_SIZE;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_mem_arb.sv
// Self-checking bench for the IFU/LSU memory-port arbiter.
module tb_ysyx_24110006_mem_arb;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_ifu_req_valid = 1'b0;
  logic        o_ifu_req_ready;
  logic [31:0] i_ifu_addr = '0;
  logic        o_ifu_resp_valid;
  logic        i_lsu_req_valid = 1'b0;
  logic        o_lsu_req_ready;
  logic [31:0] i_lsu_addr = '0;
  logic        i_lsu_wen = 1'b0;
  logic [31:0] i_lsu_wdata = '0;
  logic [3:0]  i_lsu_wmask = '0;
  logic [2:0]  i_lsu_size = '0;
  logic        o_lsu_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_s_req_valid;
  logic        i_s_req_ready = 1'b0;
  logic [31:0] o_s_addr;
  logic        o_s_wen;
  logic [31:0] o_s_wdata;
  logic [3:0]  o_s_wmask;
  logic [2:0]  o_s_size;
  logic        i_s_resp_valid = 1'b0;
  logic [31:0] i_s_rdata = '0;
  logic        i_s_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clock = ~i_clock;

  ysyx_24110006_mem_arb #(.AW(32), .DW(32)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_flush         (i_flush),
    .i_ifu_req_valid (i_ifu_req_valid),
    .o_ifu_req_ready (o_ifu_req_ready),
    .i_ifu_addr      (i_ifu_addr),
    .o_ifu_resp_valid(o_ifu_resp_valid),
    .i_lsu_req_valid (i_lsu_req_valid),
    .o_lsu_req_ready (o_lsu_req_ready),
    .i_lsu_addr      (i_lsu_addr),
    .i_lsu_wen       (i_lsu_wen),
    .i_lsu_wdata     (i_lsu_wdata),
    .i_lsu_wmask     (i_lsu_wmask),
    .i_lsu_size      (i_lsu_size),
    .o_lsu_resp_valid(o_lsu_resp_valid),
    .o_resp_rdata    (o_resp_rdata),
    .o_resp_err      (o_resp_err),
    .o_s_req_valid   (o_s_req_valid),
    .i_s_req_ready   (i_s_req_ready),
    .o_s_addr        (o_s_addr),
    .o_s_wen         (o_s_wen),
    .o_s_wdata       (o_s_wdata),
    .o_s_wmask       (o_s_wmask),
    .o_s_size        (o_s_size),
    .i_s_resp_valid  (i_s_resp_valid),
    .i_s_rdata       (i_s_rdata),
    .i_s_err         (i_s_err)
  );

  // Inputs change just after the rising edge; outputs are observed on the falling edge.
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clock);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  // Slave side of one transaction, entered in the first request cycle.
  task automatic finish_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] data,
                            output logic got_ifu, output logic got_lsu, output logic [31:0] got_rdata);
    got_ifu = 1'b0;
    got_lsu = 1'b0;
    got_rdata = '0;
    for (int k = 0; k <= rdy_dly; k++) begin
      i_s_req_ready = (k == rdy_dly);
      step();
    end
    i_s_req_ready = 1'b0;
    for (int k = 0; k <= rsp_dly; k++) begin
      i_s_resp_valid = (k == rsp_dly);
      i_s_rdata = data;
      sample();
      if (k == rsp_dly) begin
        got_ifu = o_ifu_resp_valid;
        got_lsu = o_lsu_resp_valid;
        got_rdata = o_resp_rdata;
      end
      step();
    end
    i_s_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_ifu_req_valid = 1'b1;
    i_lsu_req_valid = 1'b1;
    i_s_req_ready = 1'b1;
    i_s_resp_valid = 1'b1;
    step();
    step();
    sample();
    n_checks++; if ({o_ifu_req_ready, o_lsu_req_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {o_ifu_req_ready, o_lsu_req_ready}); end
    n_checks++; if ({o_s_req_valid, o_ifu_resp_valid, o_lsu_resp_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_valid got=%b exp=000", {o_s_req_valid, o_ifu_resp_valid, o_lsu_resp_valid}); end
    n_checks++; if ({o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_s_size} !== 72'd0) begin n_fail++; $display("FAIL reset_sregs got=%h exp=0", {o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_s_size}); end
    step();
    i_reset = 1'b0;
    i_ifu_req_valid = 1'b0;
    i_lsu_req_valid = 1'b0;
    i_s_req_ready = 1'b0;
    i_s_resp_valid = 1'b0;
  endtask

  task automatic test_solo_ifu();
    i_ifu_req_valid = 1'b1;
    i_ifu_addr = 32'h8000_0000;
    sample();
    n_checks++; if ({o_ifu_req_ready, o_lsu_req_ready, o_s_req_valid} !== 3'b100) begin n_fail++; $display("FAIL solo_accept got=%b exp=100", {o_ifu_req_ready, o_lsu_req_ready, o_s_req_valid}); end
    step();
    i_ifu_req_valid = 1'b0;
    i_ifu_addr = 32'hDEAD_BEEF;
    i_s_req_ready = 1'b1;
    sample();
    n_checks++; if (o_s_req_valid !== 1'b1) begin n_fail++; $display("FAIL solo_s_req_valid got=%b exp=1", o_s_req_valid); end
    n_checks++; if ({o_s_addr, o_s_wen, o_s_wmask, o_s_size} !== {32'h8000_0000, 1'b0, 4'h0, 3'b010}) begin n_fail++; $display("FAIL solo_s_fields got=%h/%b/%h/%b exp=80000000/0/0/010", o_s_addr, o_s_wen, o_s_wmask, o_s_size); end
    step();
    i_s_req_ready = 1'b0;
    i_s_resp_valid = 1'b1;
    i_s_rdata = 32'h0000_0413;
    sample();
    n_checks++; if ({o_s_req_valid, o_ifu_resp_valid, o_lsu_resp_valid} !== 3'b010) begin n_fail++; $display("FAIL solo_resp_strobes got=%b exp=010", {o_s_req_valid, o_ifu_resp_valid, o_lsu_resp_valid}); end
    n_checks++; if (o_resp_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL solo_rdata got=%h exp=00000413", o_resp_rdata); end
    step();
    i_s_resp_valid = 1'b0;
    sample();
    n_checks++; if ({o_ifu_resp_valid, o_lsu_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL solo_resp_one_cycle got=%b exp=00", {o_ifu_resp_valid, o_lsu_resp_valid}); end
    step();
  endtask

  task automatic test_tie();
    logic last_lsu, exp_lsu, gi, gl;
    logic [31:0] gr, d;
    logic [2:0] order;
    do_reset();
    last_lsu = 1'b0;
    order = '0;
    i_ifu_req_valid = 1'b1;
    i_lsu_req_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      i_ifu_addr = $urandom;
      i_lsu_addr = $urandom;
      sample();
      exp_lsu = !last_lsu;
      n_checks++; if ({o_lsu_req_ready, o_ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin n_fail++; $display("FAIL tie_grant%0d got lsu/ifu=%b exp=%b", t, {o_lsu_req_ready, o_ifu_req_ready}, {exp_lsu, !exp_lsu}); end
      order[t] = o_lsu_req_ready;
      step();
      last_lsu = exp_lsu;
      d = $urandom;
      finish_txn(0, 0, d, gi, gl, gr);
      n_checks++; if ({gl, gi, gr} !== {exp_lsu, !exp_lsu, d}) begin n_fail++; $display("FAIL tie_resp%0d got=%b%b/%h exp=%b%b/%h", t, gl, gi, gr, exp_lsu, !exp_lsu, d); end
    end
    n_checks++; if (order !== 3'b101) begin n_fail++; $display("FAIL tie_order got=%b exp=101 (lsu,ifu,lsu)", order); end
    i_ifu_req_valid = 1'b0;
    i_lsu_req_valid = 1'b0;
  endtask

  task automatic test_store();
    logic gi, gl;
    logic [31:0] gr;
    i_lsu_req_valid = 1'b1;
    i_lsu_addr = 32'hA000_03F8;
    i_lsu_wen = 1'b1;
    i_lsu_wdata = 32'h0000_0041;
    i_lsu_wmask = 4'b0001;
    i_lsu_size = 3'd0;
    sample();
    n_checks++; if (o_lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_accept got=%b exp=1", o_lsu_req_ready); end
    step();
    i_lsu_req_valid = 1'b0;
    i_lsu_addr = 32'h1234_5678;
    i_lsu_wen = 1'b0;
    i_lsu_wdata = 32'hFFFF_FFFF;
    i_lsu_wmask = 4'b1111;
    i_lsu_size = 3'd2;
    for (int k = 0; k < 5; k++) begin
      sample();
      n_checks++; if ({o_s_req_valid, o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_s_size} !== {1'b1, 32'hA000_03F8, 1'b1, 32'h41, 4'b0001, 3'd0}) begin n_fail++; $display("FAIL store_hold%0d got v=%b a=%h w=%b d=%h m=%b s=%0d", k, o_s_req_valid, o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_s_size); end
      step();
    end
    finish_txn(0, 0, 32'h0, gi, gl, gr);
    n_checks++; if ({gl, gi} !== 2'b10) begin n_fail++; $display("FAIL store_resp got lsu/ifu=%b%b exp=10", gl, gi); end
    i_lsu_wen = 1'b0;
  endtask

  task automatic test_flush_kill(input int mode);
    logic gi, gl;
    logic [31:0] gr, d;
    i_ifu_req_valid = 1'b1;
    i_ifu_addr = $urandom;
    sample();
    n_checks++; if (o_ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush%0d_accept got=%b exp=1", mode, o_ifu_req_ready); end
    step();
    i_ifu_req_valid = 1'b0;
    if (mode == 1) begin
      i_flush = 1'b1;
      sample();
      n_checks++; if (o_s_req_valid !== 1'b1) begin n_fail++; $display("FAIL flush1_req_held got=%b exp=1", o_s_req_valid); end
      step();
      i_flush = 1'b0;
    end
    i_s_req_ready = 1'b1;
    step();
    i_s_req_ready = 1'b0;
    if (mode == 0) begin
      i_flush = 1'b1;
      sample();
      n_checks++; if (o_ifu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush0_wait_resp got=%b exp=0", o_ifu_resp_valid); end
      step();
      i_flush = 1'b0;
    end
    i_s_resp_valid = 1'b1;
    i_s_rdata = $urandom;
    i_flush = (mode == 2);
    i_ifu_req_valid = 1'b1;
    sample();
    n_checks++; if ({o_ifu_resp_valid, o_lsu_resp_valid, o_ifu_req_ready} !== 3'b000) begin n_fail++; $display("FAIL flush%0d_drop got resp/resp/ready=%b exp=000", mode, {o_ifu_resp_valid, o_lsu_resp_valid, o_ifu_req_ready}); end
    step();
    i_s_resp_valid = 1'b0;
    i_flush = 1'b0;
    sample();
    n_checks++; if (o_ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush%0d_next_accept got=%b exp=1", mode, o_ifu_req_ready); end
    step();
    i_ifu_req_valid = 1'b0;
    d = $urandom;
    finish_txn(0, 1, d, gi, gl, gr);
    n_checks++; if ({gi, gl, gr} !== {2'b10, d}) begin n_fail++; $display("FAIL flush%0d_next_resp got=%b%b/%h exp=10/%h", mode, gi, gl, gr, d); end
  endtask

  task automatic test_flush_lsu();
    logic gi, gl;
    logic [31:0] gr, d;
    i_lsu_req_valid = 1'b1;
    i_lsu_wen = 1'b0;
    i_lsu_addr = 32'h8000_1000;
    i_flush = 1'b1;
    sample();
    n_checks++; if (o_lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_lsu_accept got=%b exp=1", o_lsu_req_ready); end
    step();
    i_lsu_req_valid = 1'b0;
    d = 32'hCAFE_F00D;
    finish_txn(1, 1, d, gi, gl, gr);
    n_checks++; if ({gl, gi, gr} !== {2'b10, d}) begin n_fail++; $display("FAIL flush_lsu_resp got=%b%b/%h exp=10/%h", gl, gi, gr, d); end
    i_flush = 1'b0;
  endtask

  task automatic test_reset_wait();
    logic gi, gl;
    logic [31:0] gr;
    i_lsu_req_valid = 1'b1;
    i_lsu_addr = 32'h0000_0FF0;
    sample();
    n_checks++; if (o_lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_accept got=%b exp=1", o_lsu_req_ready); end
    step();
    i_lsu_req_valid = 1'b0;
    i_s_req_ready = 1'b1;
    step();
    i_s_req_ready = 1'b0;
    i_reset = 1'b1;
    i_ifu_req_valid = 1'b1;
    i_lsu_req_valid = 1'b1;
    i_s_resp_valid = 1'b1;
    sample();
    n_checks++; if ({o_ifu_req_ready, o_lsu_req_ready, o_s_req_valid, o_ifu_resp_valid, o_lsu_resp_valid} !== 5'b0) begin n_fail++; $display("FAIL rstwait_during got=%b exp=00000", {o_ifu_req_ready, o_lsu_req_ready, o_s_req_valid, o_ifu_resp_valid, o_lsu_resp_valid}); end
    step();
    i_reset = 1'b0;
    i_s_resp_valid = 1'b0;
    sample();
    n_checks++; if ({o_lsu_req_ready, o_ifu_req_ready, o_s_req_valid, o_lsu_resp_valid} !== 4'b1000) begin n_fail++; $display("FAIL rstwait_after got lsu/ifu/sv/resp=%b exp=1000", {o_lsu_req_ready, o_ifu_req_ready, o_s_req_valid, o_lsu_resp_valid}); end
    n_checks++; if (o_s_addr !== 32'h0) begin n_fail++; $display("FAIL rstwait_addr got=%h exp=0", o_s_addr); end
    step();
    i_ifu_req_valid = 1'b0;
    i_lsu_req_valid = 1'b0;
    finish_txn(0, 0, 32'h5, gi, gl, gr);
  endtask

  // Random traffic; the model tracks only who was granted last and what each grant must carry.
  task automatic test_random();
    logic last_lsu, iv, lv, exp_lsu, fl, killed, dlv, err;
    logic [31:0] ia, la, wd, data;
    logic [3:0]  wm;
    logic [2:0]  sz;
    logic        we;
    logic [71:0] exp_s;
    int rd, rs;
    do_reset();
    last_lsu = 1'b0;
    for (int it = 0; it < 60; it++) begin
      iv = $urandom_range(0, 1);
      lv = $urandom_range(0, 1);
      if (!iv && !lv) iv = 1'b1;
      ia = $urandom; la = $urandom; wd = $urandom;
      wm = 4'($urandom); sz = 3'($urandom); we = 1'($urandom);
      i_ifu_req_valid = iv; i_ifu_addr = ia;
      i_lsu_req_valid = lv; i_lsu_addr = la; i_lsu_wen = we;
      i_lsu_wdata = wd; i_lsu_wmask = wm; i_lsu_size = sz;
      exp_lsu = lv && (!iv || !last_lsu);
      sample();
      n_checks++; if ({o_ifu_req_ready, o_lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin n_fail++; $display("FAIL rand%0d_grant got ifu/lsu=%b exp=%b", it, {o_ifu_req_ready, o_lsu_req_ready}, {!exp_lsu, exp_lsu}); end
      step();
      last_lsu = exp_lsu;
      i_ifu_req_valid = 1'b0;
      i_lsu_req_valid = 1'b0;
      exp_s = exp_lsu ? {la, we, wd, wm, sz} : {ia, 1'b0, 32'h0, 4'h0, 3'b010};
      fl = ($urandom_range(0, 2) == 0);
      killed = fl && !exp_lsu;
      i_flush = fl;
      rd = $urandom_range(0, 3);
      for (int k = 0; k <= rd; k++) begin
        i_s_req_ready = (k == rd);
        sample();
        n_checks++; if ({o_s_req_valid, o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_s_size} !== {1'b1, exp_s}) begin n_fail++; $display("FAIL rand%0d_sreq got=%b/%h exp=1/%h", it, o_s_req_valid, {o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_s_size}, exp_s); end
        step();
      end
      i_s_req_ready = 1'b0;
      rs = $urandom_range(0, 3);
      data = $urandom;
      err = 1'($urandom);
      for (int k = 0; k <= rs; k++) begin
        i_s_resp_valid = (k == rs);
        i_s_rdata = data;
        i_s_err = err;
        dlv = (k == rs) && !killed;
        sample();
        n_checks++; if ({o_ifu_resp_valid, o_lsu_resp_valid} !== {dlv && !exp_lsu, dlv && exp_lsu}) begin n_fail++; $display("FAIL rand%0d_resp k=%0d got ifu/lsu=%b exp=%b", it, k, {o_ifu_resp_valid, o_lsu_resp_valid}, {dlv && !exp_lsu, dlv && exp_lsu}); end
        n_checks++; if ({o_resp_rdata, o_resp_err} !== (dlv ? {data, err} : 33'h0)) begin n_fail++; $display("FAIL rand%0d_rdata k=%0d got=%h/%b exp=%h/%b", it, k, o_resp_rdata, o_resp_err, dlv ? data : 32'h0, dlv && err); end
        step();
      end
      i_s_resp_valid = 1'b0;
      i_s_err = 1'b0;
      i_flush = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_solo_ifu();
    test_tie();
    test_store();
    test_flush_kill(0);
    test_flush_kill(1);
    test_flush_kill(2);
    test_flush_lsu();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
